btn_debounce: RTL and testbench

Debounces one raw mechanical push-button input and produces a clean, registered level `stable` for the downstream one-cycle rising-edge pulse generator. The block sits between the board button pin and the pulse stage, one instance per button. It has a metastability synchronizer, a four-state confirm/release FSM with a stability counter, and an optional long-press detector.

---
 rtl/btn_debounce.sv | 154 +++++++++++++++
 tb/tb_btn_debounce.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: debounces one raw push-button level into a clean, registered
// `stable` level for the downstream rising-edge pulse stage.
// Structure: SYNC_STAGES-deep synchronizer, four-state confirm/release FSM
// with a stability counter, and an optional long-press detector.
// Optional feature macro: BTN_DEBOUNCE_LONG_EN. When it is defined, the
// long-press counter and `long_press` pulse are built. When it is undefined,
// `long_press` is tied low and LONG_MAX has no effect.
module btn_debounce #(
    parameter int CNT_MAX     = 1_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int LONG_MAX    = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic stable,
    output logic long_press
);

    localparam int CW = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE,
        S_HIGH,
        S_FALL
    } state_t;

    logic [SYNC_STAGES-1:0] syncPipe_q;
    logic                   syncLevel;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;

    // Shift the raw asynchronous button level through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncPipe_q <= '0;
        end else begin
            syncPipe_q <= {syncPipe_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign syncLevel = syncPipe_q[SYNC_STAGES-1];

    // State, stability counter and debounced level all advance on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_LOW;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // Next state: a level change is confirmed only after an unbroken run of
    // equal samples; any opposite sample falls back to the prior settled state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (syncLevel) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end
            end
            S_RISE: begin
                if (!syncLevel) begin
                    state_d = S_LOW;
                end else if (cnt_q == CW'(CNT_MAX - 1)) begin
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (!syncLevel) begin
                    state_d = S_FALL;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (syncLevel) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CW'(CNT_MAX - 1)) begin
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Debounced level is high exactly while the FSM sits in S_HIGH or S_FALL.
    always_comb begin
        stable_d = (state_d == S_HIGH) || (state_d == S_FALL);
    end

    assign stable = stable_q;

`ifdef BTN_DEBOUNCE_LONG_EN
    localparam int LW = $clog2(LONG_MAX + 1);

    logic [LW-1:0] longCnt_q, longCnt_d;
    logic          longPress_q, longPress_d;

    // Long counter runs in S_HIGH, holds across a release bounce in S_FALL,
    // clears while low; it saturates at LONG_MAX so each press fires once.
    always_comb begin
        longCnt_d   = longCnt_q;
        longPress_d = 1'b0;
        case (state_q)
            S_HIGH: begin
                if (longCnt_q == LW'(LONG_MAX - 1)) begin
                    longPress_d = 1'b1;
                end
                if (longCnt_q < LW'(LONG_MAX)) begin
                    longCnt_d = longCnt_q + LW'(1);
                end
            end
            S_FALL: begin
                longCnt_d = longCnt_q;
            end
            default: begin
                longCnt_d = '0;
            end
        endcase
    end

    // Register the long counter and the one-cycle long-press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            longCnt_q   <= '0;
            longPress_q <= 1'b0;
        end else begin
            longCnt_q   <= longCnt_d;
            longPress_q <= longPress_d;
        end
    end

    assign long_press = longPress_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: scoreboard bench for btn_debounce with CNT_MAX=4,
// SYNC_STAGES=2, LONG_MAX=10. Honours BTN_DEBOUNCE_LONG_EN the same way the
// design does, so it works in both builds.
module tb_btn_debounce;

    localparam int CNT_MAX     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LONG_MAX    = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_in = 1'b0;
    logic stable;
    logic long_press;

    int vectorCount     = 0;
    int miscompareCount = 0;
    int longSeen        = 0;

    // Expected {stable, long_press} after each upcoming clock edge.
    logic [1:0] expQ[$];

    // Reference model state.
    logic [SYNC_STAGES-1:0] mPipe  = '0;
    logic                   mStable = 1'b0;
    int                     mRun    = 0;
    int                     mLong   = 0;

    btn_debounce #(
        .CNT_MAX(CNT_MAX),
        .SYNC_STAGES(SYNC_STAGES),
        .LONG_MAX(LONG_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .stable(stable),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Clear the model to its post-reset state.
    task automatic resetModel();
        mPipe   = '0;
        mStable = 1'b0;
        mRun    = 0;
        mLong   = 0;
        expQ.delete();
    endtask

    // Drive one button sample at the falling edge and predict the outputs
    // after the following rising edge. The model counts how many consecutive
    // synchronized samples disagree with the current debounced level.
    task automatic applyStimulus(input logic b);
        logic seen;
        logic expLong;
        btn_in  = b;
        seen    = mPipe[SYNC_STAGES-1];
        mPipe   = {mPipe[SYNC_STAGES-2:0], b};
        expLong = 1'b0;
        if (mStable && mRun == 0) begin
            if (mLong == LONG_MAX - 1) expLong = 1'b1;
            if (mLong < LONG_MAX) mLong++;
        end else if (!mStable) begin
            mLong = 0;
        end
        if (seen != mStable) begin
            mRun++;
            if (mRun == CNT_MAX + 1) begin
                mStable = seen;
                mRun    = 0;
            end
        end else begin
            mRun = 0;
        end
`ifndef BTN_DEBOUNCE_LONG_EN
        expLong = 1'b0;
`endif
        expQ.push_back({mStable, expLong});
        @(negedge clk);
    endtask

    task automatic holdLevel(input logic b, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(b);
    endtask

    // Compare DUT outputs shortly after each rising edge against the queue.
    always @(posedge clk) begin
        logic [1:0] e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("stable", 32'(stable), 32'(e[1]));
            checkOutput("long_press", 32'(long_press), 32'(e[0]));
            if (long_press) longSeen++;
        end
    end

    // Directed scenarios: reset, clean press, bounce rejection, release
    // bounce, long press twice, and asynchronous reset mid-rise.
    initial begin
        int expPulses;
`ifdef BTN_DEBOUNCE_LONG_EN
        expPulses = 1;
`else
        expPulses = 0;
`endif
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_stable", 32'(stable), 32'd0);
        checkOutput("reset_long", 32'(long_press), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        resetModel();

        $display("[TB] clean press and release");
        holdLevel(1'b1, 12);
        checkOutput("press_level", 32'(stable), 32'd1);
        holdLevel(1'b0, 12);
        checkOutput("release_level", 32'(stable), 32'd0);

        $display("[TB] bounce rejection");
        for (int r = 0; r < 4; r++) begin
            holdLevel(1'b1, 3);
            holdLevel(1'b0, 1);
            holdLevel(1'b1, 3);
            holdLevel(1'b0, 1);
        end
        holdLevel(1'b0, 10);
        checkOutput("bounce_level", 32'(stable), 32'd0);

        $display("[TB] release bounce");
        holdLevel(1'b1, 12);
        holdLevel(1'b0, 3);
        holdLevel(1'b1, 10);
        checkOutput("rel_bounce_level", 32'(stable), 32'd1);
        holdLevel(1'b0, 12);

        $display("[TB] long press twice");
        longSeen = 0;
        holdLevel(1'b1, 30);
        checkOutput("long_pulses_1", 32'(longSeen), 32'(expPulses));
        holdLevel(1'b0, 12);
        longSeen = 0;
        holdLevel(1'b1, 30);
        checkOutput("long_pulses_2", 32'(longSeen), 32'(expPulses));
        holdLevel(1'b0, 12);

        $display("[TB] async reset mid-rise");
        holdLevel(1'b1, 4);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrise_stable", 32'(stable), 32'd0);
        checkOutput("midrise_long", 32'(long_press), 32'd0);
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        resetModel();
        holdLevel(1'b1, 6);
        checkOutput("post_reset_6", 32'(stable), 32'd0);
        holdLevel(1'b1, 1);
        checkOutput("post_reset_7", 32'(stable), 32'd1);
        holdLevel(1'b1, 4);
        holdLevel(1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectorCount, miscompareCount);
        $finish;
    end

endmodule
